led_shift_ctrl: RTL

- Consumes the one-cycle shift strobe from the limit counter (`o_shift_enable`) and drives an N-bit LED pattern register.
- Four selectable patterns: rotate left, rotate right, ping-pong (bounce), flash.
- Sits directly downstream of the counter; its outputs drive the board LEDs.
- Reports the end of each pattern period with a one-cycle pulse, for a later sequencing stage.

---
 rtl/led_shift_ctrl_pkg.sv | 30 +++
 rtl/led_shift_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/led_shift_ctrl_pkg.sv
// Shared constants and helpers for the LED pattern controller.
// Pattern modes, the ping-pong direction type and the per-mode seed pattern.
package led_shift_ctrl_pkg;

  localparam logic [1:0] MODE_ROTL  = 2'b00;
  localparam logic [1:0] MODE_ROTR  = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;
  localparam logic [1:0] MODE_FLASH = 2'b11;

  // The seed helper returns a fixed-width word; callers cast it down to N_LEDS.
  localparam int unsigned SEED_W = 32;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  function automatic logic [SEED_W-1:0] seed(input logic [1:0] mode,
                                             input int unsigned n);
    logic [SEED_W-1:0] one;
    one  = {{(SEED_W-1){1'b0}}, 1'b1};
    seed = '0;
    case (mode)
      MODE_ROTL, MODE_PING: seed = one;
      MODE_ROTR:            seed = one << (n - 1);
      default:              seed = '0;
    endcase
  endfunction

endpackage

// File: rtl/led_shift_ctrl.sv
// LED pattern register advanced by a one-cycle strobe: rotate left/right,
// ping-pong and flash, with a registered one-cycle period-complete pulse.
//
//   state     | meaning
//   DIR_LEFT  | ping-pong travelling towards the MSB (also the idle/reset state)
//   DIR_RIGHT | ping-pong travelling back towards the LSB
module led_shift_ctrl
  import led_shift_ctrl_pkg::*;
#(
  parameter int unsigned N_LEDS = 4
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_shift_enable,
  input  logic [1:0]        i_mode,
  input  logic              i_hold,
  output logic [N_LEDS-1:0] o_leds,
  output logic              o_wrap
);

  logic [N_LEDS-1:0] r_leds;
  logic              r_wrap;
  logic [1:0]        r_mode;
  dir_t              r_dir;

  logic [N_LEDS-1:0] w_leds_nxt;
  logic              w_wrap_nxt;
  logic [1:0]        w_mode_nxt;
  dir_t              w_dir_nxt;

  logic [N_LEDS-1:0] w_seed_new;
  logic [N_LEDS-1:0] w_seed_cur;
  logic              w_mode_chg;
  logic              w_advance;
  logic              w_legal;

  assign w_seed_new = N_LEDS'(seed(i_mode, N_LEDS));
  assign w_seed_cur = N_LEDS'(seed(r_mode, N_LEDS));
  assign w_mode_chg = (i_mode != r_mode);
  assign w_advance  = i_shift_enable && !i_hold;

  always_comb begin
    w_legal = $onehot(r_leds);
    if (r_mode == MODE_FLASH) begin
      w_legal = (r_leds == '0) || (&r_leds);
    end
  end

  always_comb begin
    w_leds_nxt = r_leds;
    w_wrap_nxt = 1'b0;
    w_mode_nxt = r_mode;
    w_dir_nxt  = r_dir;

    if (w_mode_chg) begin
      w_mode_nxt = i_mode;
      w_leds_nxt = w_seed_new;
      w_dir_nxt  = DIR_LEFT;
    end else if (w_advance) begin
      if (!w_legal) begin
        // Corrupted pattern: restart the current mode cleanly.
        w_leds_nxt = w_seed_cur;
        w_dir_nxt  = DIR_LEFT;
      end else begin
        case (r_mode)
          MODE_ROTL: begin
            w_leds_nxt = {r_leds[N_LEDS-2:0], r_leds[N_LEDS-1]};
            w_wrap_nxt = r_leds[N_LEDS-1];
          end
          MODE_ROTR: begin
            w_leds_nxt = {r_leds[0], r_leds[N_LEDS-1:1]};
            w_wrap_nxt = r_leds[0];
          end
          MODE_PING: begin
            // Turn around on the advance that lands on an end, so ends are not repeated.
            if (r_dir == DIR_LEFT) begin
              if (r_leds[N_LEDS-1]) begin
                w_leds_nxt = r_leds >> 1;
                w_dir_nxt  = DIR_RIGHT;
              end else begin
                w_leds_nxt = r_leds << 1;
                if (r_leds[N_LEDS-2]) w_dir_nxt = DIR_RIGHT;
              end
            end else begin
              if (r_leds[0]) begin
                w_leds_nxt = r_leds << 1;
                w_dir_nxt  = DIR_LEFT;
              end else begin
                w_leds_nxt = r_leds >> 1;
                if (r_leds[1]) begin
                  w_dir_nxt  = DIR_LEFT;
                  w_wrap_nxt = 1'b1;
                end
              end
            end
          end
          default: begin
            w_leds_nxt = ~r_leds;
            w_wrap_nxt = &r_leds;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_leds <= N_LEDS'(1);
      r_wrap <= 1'b0;
      r_mode <= MODE_ROTL;
      r_dir  <= DIR_LEFT;
    end else begin
      r_leds <= w_leds_nxt;
      r_wrap <= w_wrap_nxt;
      r_mode <= w_mode_nxt;
      r_dir  <= w_dir_nxt;
    end
  end

  assign o_leds = r_leds;
  assign o_wrap = r_wrap;

endmodule
